// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache: controller state encoding and the
// pmem address-mux select values.
package lc3b_types;

    typedef enum logic [1:0] {
        S_IDLE_HIT = 2'd0,
        S_WB       = 2'd1,
        S_ALLOC    = 2'd2
    } lc3b_cache_state;

    typedef logic [1:0] lc3b_pmemaddr_sel;

    localparam lc3b_pmemaddr_sel PMA_CPU  = 2'd0;
    localparam lc3b_pmemaddr_sel PMA_WAY0 = 2'd1;
    localparam lc3b_pmemaddr_sel PMA_WAY1 = 2'd2;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        i_clr_n,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_count <= 16'd0;
        end else if (i_inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way LC-3b cache: hit handling, dirty writeback and
// line allocation against pmem, plus saturating hit/miss counters.
module cache_control
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        hit,
    input  logic        hit1,
    input  logic        lru_out,
    input  logic        d_out0,
    input  logic        d_out1,
    output logic        load_lru,
    output logic        writeback_ctrlsig,
    output logic        load_d0,
    output logic        load_v0,
    output logic        load_TD0,
    output logic        d_in0,
    output logic        v_in0,
    output logic        load_d1,
    output logic        load_v1,
    output logic        load_TD1,
    output logic        d_in1,
    output logic        v_in1,
    output logic [1:0]  pmemaddr_sel,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    lc3b_cache_state r_state;
    logic            r_victim;
    logic            r_retry;

    logic w_req;
    logic w_victim_dirty;
    logic w_hit_inc;
    logic w_miss_inc;

    assign w_req          = mem_read | mem_write;
    assign w_victim_dirty = lru_out ? d_out1 : d_out0;
    // The hit that completes a miss was already counted as a miss.
    assign w_hit_inc      = (r_state == S_IDLE_HIT) & w_req & hit & ~r_retry;
    assign w_miss_inc     = (r_state == S_IDLE_HIT) & w_req & ~hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE_HIT;
            r_victim <= 1'b0;
            r_retry  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE_HIT: begin
                    if (!w_req || hit) begin
                        r_retry <= 1'b0;
                    end else begin
                        r_victim <= lru_out;
                        r_state  <= w_victim_dirty ? S_WB : S_ALLOC;
                    end
                end
                S_WB: begin
                    if (pmem_resp) r_state <= S_ALLOC;
                end
                S_ALLOC: begin
                    if (pmem_resp) begin
                        r_retry <= 1'b1;
                        r_state <= S_IDLE_HIT;
                    end
                end
                default: r_state <= S_IDLE_HIT;
            endcase
        end
    end

    always_comb begin
        mem_resp          = 1'b0;
        load_lru          = 1'b0;
        writeback_ctrlsig = 1'b0;
        load_d0           = 1'b0;
        load_v0           = 1'b0;
        load_TD0          = 1'b0;
        d_in0             = 1'b0;
        v_in0             = 1'b0;
        load_d1           = 1'b0;
        load_v1           = 1'b0;
        load_TD1          = 1'b0;
        d_in1             = 1'b0;
        v_in1             = 1'b0;
        pmemaddr_sel      = PMA_CPU;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        case (r_state)
            S_IDLE_HIT: begin
                if (w_req && hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    if (mem_write) begin
                        load_TD0 = ~hit1;
                        load_d0  = ~hit1;
                        d_in0    = ~hit1;
                        load_TD1 = hit1;
                        load_d1  = hit1;
                        d_in1    = hit1;
                    end
                end
            end
            S_WB: begin
                pmem_write        = 1'b1;
                pmemaddr_sel      = r_victim ? PMA_WAY1 : PMA_WAY0;
                writeback_ctrlsig = ~r_victim;
                if (pmem_resp) begin
                    load_d0 = ~r_victim;
                    load_d1 = r_victim;
                end
            end
            S_ALLOC: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_TD0 = ~r_victim;
                    load_v0  = ~r_victim;
                    v_in0    = ~r_victim;
                    load_d0  = ~r_victim;
                    load_TD1 = r_victim;
                    load_v1  = r_victim;
                    v_in1    = r_victim;
                    load_d1  = r_victim;
                end
            end
            default: ;
        endcase
    end

    sat_counter16 u_hit_cnt (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_inc   (w_hit_inc),
        .o_count (hit_count)
    );

    sat_counter16 u_miss_cnt (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_inc   (w_miss_inc),
        .o_count (miss_count)
    );

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: per-cycle output vectors plus a counter scoreboard
// checked whenever mem_resp fires.
module tb_cache_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, hit1 = 1'b0;
    logic lru_out = 1'b0, d_out0 = 1'b0, d_out1 = 1'b0, pmem_resp = 1'b0;
    logic mem_resp, load_lru, writeback_ctrlsig;
    logic load_d0, load_v0, load_TD0, d_in0, v_in0;
    logic load_d1, load_v1, load_TD1, d_in1, v_in1;
    logic [1:0] pmemaddr_sel;
    logic pmem_read, pmem_write;
    logic [15:0] hit_count, miss_count;

    cache_control dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .hit1(hit1), .lru_out(lru_out), .d_out0(d_out0), .d_out1(d_out1),
        .load_lru(load_lru), .writeback_ctrlsig(writeback_ctrlsig),
        .load_d0(load_d0), .load_v0(load_v0), .load_TD0(load_TD0), .d_in0(d_in0), .v_in0(v_in0),
        .load_d1(load_d1), .load_v1(load_v1), .load_TD1(load_TD1), .d_in1(d_in1), .v_in1(v_in1),
        .pmemaddr_sel(pmemaddr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef logic [16:0] ovec_t;
    localparam ovec_t MR   = 17'h10000;
    localparam ovec_t LL   = 17'h08000;
    localparam ovec_t WBC  = 17'h04000;
    localparam ovec_t LD0  = 17'h02000;
    localparam ovec_t LV0  = 17'h01000;
    localparam ovec_t LT0  = 17'h00800;
    localparam ovec_t DI0  = 17'h00400;
    localparam ovec_t VI0  = 17'h00200;
    localparam ovec_t LD1  = 17'h00100;
    localparam ovec_t LV1  = 17'h00080;
    localparam ovec_t LT1  = 17'h00040;
    localparam ovec_t DI1  = 17'h00020;
    localparam ovec_t VI1  = 17'h00010;
    localparam ovec_t SEL1 = 17'h00004;
    localparam ovec_t SEL2 = 17'h00008;
    localparam ovec_t PR   = 17'h00002;
    localparam ovec_t PW   = 17'h00001;
    localparam ovec_t NONE = 17'h00000;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] m;
    } cnt_t;

    typedef struct {
        string nm;
        logic  rd, wr, h, h1, lru, d0, d1;
        logic  cnt;
        ovec_t exp;
    } vec_t;

    cnt_t  sbq[$];
    cnt_t  sb_e;
    vec_t  tbl[6];
    int    n_chk = 0;
    int    n_fail = 0;
    logic [15:0] exp_hit = 16'd0;
    logic [15:0] exp_miss = 16'd0;

    function automatic ovec_t pack_out();
        return {mem_resp, load_lru, writeback_ctrlsig,
                load_d0, load_v0, load_TD0, d_in0, v_in0,
                load_d1, load_v1, load_TD1, d_in1, v_in1,
                pmemaddr_sel, pmem_read, pmem_write};
    endfunction

    task automatic expect_now(input string nm, input ovec_t e);
        ovec_t got;
        got = pack_out();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: outputs=%05h required=%05h", nm, got, e);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [15:0] eh, input logic [15:0] em);
        n_chk++;
        if (hit_count !== eh || miss_count !== em) begin
            n_fail++;
            $display("FAIL %s: hit_count=%0d miss_count=%0d required %0d/%0d",
                     nm, hit_count, miss_count, eh, em);
        end
    endtask

    task automatic step(input string nm, input logic rd, input logic wr, input logic h,
                        input logic h1, input logic lru, input logic d0, input logic d1,
                        input logic pr, input ovec_t e);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; hit = h; hit1 = h1;
        lru_out = lru; d_out0 = d0; d_out1 = d1; pmem_resp = pr;
        @(negedge clk);
        expect_now(nm, e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Counter scoreboard: every mem_resp must match a pushed expectation.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && mem_resp) begin
                    n_chk++;
                    if (sbq.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected_resp: mem_resp=1 required=0");
                    end else begin
                        sb_e = sbq.pop_front();
                        if (hit_count !== sb_e.h || miss_count !== sb_e.m) begin
                            n_fail++;
                            $display("FAIL sb_counts: hit=%0d miss=%0d required %0d/%0d",
                                     hit_count, miss_count, sb_e.h, sb_e.m);
                        end
                    end
                end
            end
        join_none

        tbl[0] = '{"rd_hit_w0",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MR|LL};
        tbl[1] = '{"wr_hit_w0",     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MR|LL|LT0|LD0|DI0};
        tbl[2] = '{"rd_hit_w1",     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, MR|LL};
        tbl[3] = '{"wr_hit_w1",     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, MR|LL|LT1|LD1|DI1};
        tbl[4] = '{"no_req",        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NONE};
        tbl[5] = '{"rd_hit_dirty",  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, MR|LL};

        #2;
        expect_now("reset_outputs", NONE);
        chk_cnt("reset_counts", 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, NONE);

        // Clean miss on way0 after reset
        sbq.push_back('{h: exp_hit, m: exp_miss + 16'd1});
        step("miss0_idle",  1, 0, 0, 0, 0, 0, 0, 0, NONE);
        exp_miss++;
        step("miss0_alloc", 1, 0, 0, 0, 0, 0, 0, 0, PR);
        step("miss0_fill",  1, 0, 0, 0, 0, 0, 0, 1, PR|LT0|LV0|VI0|LD0);
        step("miss0_retry", 1, 0, 1, 0, 0, 0, 0, 0, MR|LL);
        step("idle_a",      0, 0, 0, 0, 0, 0, 0, 0, NONE);
        chk_cnt("cnt_after_miss", 16'd0, 16'd1);

        for (int i = 0; i < 6; i++) begin
            if ((tbl[i].rd || tbl[i].wr) && tbl[i].h)
                sbq.push_back('{h: exp_hit, m: exp_miss});
            step(tbl[i].nm, tbl[i].rd, tbl[i].wr, tbl[i].h, tbl[i].h1,
                 tbl[i].lru, tbl[i].d0, tbl[i].d1, 1'b0, tbl[i].exp);
            if (tbl[i].cnt) exp_hit++;
        end
        step("idle_b", 0, 0, 0, 0, 0, 0, 0, 0, NONE);
        chk_cnt("cnt_after_table", exp_hit, exp_miss);

        // Fill way1, then dirty miss evicting way0
        sbq.push_back('{h: exp_hit, m: exp_miss + 16'd1});
        step("fill1_idle",  1, 0, 0, 0, 1, 0, 0, 0, NONE);
        exp_miss++;
        step("fill1_alloc", 1, 0, 0, 0, 1, 0, 0, 0, PR);
        step("fill1_resp",  1, 0, 0, 0, 1, 0, 0, 1, PR|LT1|LV1|VI1|LD1);
        step("fill1_retry", 1, 0, 1, 1, 1, 0, 0, 0, MR|LL);
        sbq.push_back('{h: exp_hit, m: exp_miss + 16'd1});
        step("dirty_idle",  1, 0, 0, 0, 0, 1, 0, 0, NONE);
        exp_miss++;
        step("dirty_wb1",   1, 0, 0, 0, 0, 1, 0, 0, PW|SEL1|WBC);
        step("dirty_wb2",   1, 0, 0, 0, 0, 1, 0, 0, PW|SEL1|WBC);
        step("dirty_wbrsp", 1, 0, 0, 0, 0, 1, 0, 1, PW|SEL1|WBC|LD0);
        step("dirty_alloc", 1, 0, 0, 0, 0, 0, 0, 0, PR);
        step("dirty_fill",  1, 0, 0, 0, 0, 0, 0, 1, PR|LT0|LV0|VI0|LD0);
        step("dirty_retry", 1, 0, 1, 0, 1, 0, 0, 0, MR|LL);
        step("idle_c",      0, 0, 0, 0, 0, 0, 0, 0, NONE);
        chk_cnt("cnt_after_dirty", exp_hit, exp_miss);

        // CPU abandons request during allocation
        step("aband_idle",  1, 0, 0, 0, 0, 0, 0, 0, NONE);
        exp_miss++;
        step("aband_alloc", 1, 0, 0, 0, 0, 0, 0, 0, PR);
        step("aband_drop1", 0, 0, 0, 0, 0, 0, 0, 0, PR);
        step("aband_drop2", 0, 0, 0, 0, 0, 0, 0, 0, PR);
        step("aband_fill",  0, 0, 0, 0, 0, 0, 0, 1, PR|LT0|LV0|VI0|LD0);
        step("aband_norsp", 0, 0, 1, 0, 0, 0, 0, 0, NONE);
        sbq.push_back('{h: exp_hit, m: exp_miss});
        step("aband_newhit", 1, 0, 1, 0, 0, 0, 0, 0, MR|LL);
        exp_hit++;
        step("idle_d",      0, 0, 0, 0, 0, 0, 0, 0, NONE);
        chk_cnt("cnt_after_abandon", exp_hit, exp_miss);

        // Asynchronous reset in the middle of a way1 writeback
        step("rst_idle", 1, 0, 0, 0, 1, 0, 1, 0, NONE);
        step("rst_wb",   1, 0, 0, 0, 1, 0, 1, 0, PW|SEL2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("rst_async_drop", NONE);
        chk_cnt("rst_counts", 16'd0, 16'd0);
        exp_hit = 16'd0;
        exp_miss = 16'd0;
        @(posedge clk); #1;
        expect_now("rst_held", NONE);
        mem_read = 1'b0; lru_out = 1'b0; d_out1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_release_miss", 1, 0, 0, 0, 0, 0, 1, 0, NONE);
        step("rst_release_alloc", 1, 0, 0, 0, 0, 0, 1, 0, PR);
        exp_miss++;
        sbq.push_back('{h: exp_hit, m: exp_miss});
        step("rst_release_fill",  1, 0, 0, 0, 0, 0, 1, 1, PR|LT0|LV0|VI0|LD0);
        step("rst_release_retry", 1, 0, 1, 0, 0, 0, 0, 0, MR|LL);
        step("idle_e",            0, 0, 0, 0, 0, 0, 0, 0, NONE);
        chk_cnt("cnt_after_reset", exp_hit, exp_miss);

        // Hold a hitting read long enough to saturate hit_count
        @(posedge clk); #1;
        mem_read = 1'b1; hit = 1'b1; hit1 = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            sbq.push_back('{h: exp_hit, m: exp_miss});
            if (exp_hit != 16'hFFFF) exp_hit++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; hit = 1'b0;
        @(negedge clk);
        chk_cnt("hit_saturated", 16'hFFFF, exp_miss);

        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_pending: outstanding=%0d required=0", sbq.size());
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the 2-way, 8-set, 16-byte-line LC-3b cache datapath. Decides hit and miss handling from the datapath status bits, issues per-way load/valid/dirty strobes and LRU updates, and runs dirty writeback and line allocation against physical memory. Sits between the CPU memory port, the cache datapath and the pmem interface. Also keeps saturating hit and miss counters for performance debug.

## Interface
- No parameters. Address split is fixed: tag [15:7], index [6:4], word offset [3:1].
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp; never asserted together with mem_read
- mem_resp  out  1  CPU request complete, single-cycle pulse
- hit  in  1  datapath: hit in either way
- hit1  in  1  datapath: hit in way1; hit0 = hit & ~hit1
- lru_out  in  1  datapath LRU bit for the indexed set: 1 = way0 most recent, victim way1
- d_out0, d_out1  in  1  dirty bit of each way for the indexed set
- load_lru  out  1  write LRU array; the datapath writes hit0
- writeback_ctrlsig  out  1  forces the way-select mux to way0
- load_d0, load_v0, load_TD0, d_in0, v_in0  out  1 each  way0 strobes and bit values
- load_d1, load_v1, load_TD1, d_in1, v_in1  out  1 each  way1 strobes and bit values
- pmemaddr_sel  out  2  0 = CPU line address, 1 = way0 tag address, 2 = way1 tag address
- pmem_read  out  1  pmem line read; also steers datapath write-merge to pmem_rdata
- pmem_write  out  1  pmem line write
- pmem_resp  in  1  pmem transaction complete, single-cycle pulse
- hit_count, miss_count  out  16 each  saturating performance counters

## Operation
- States: S_IDLE_HIT, S_WB, S_ALLOC.
- Registered state: state, victim (1 bit), retry (1 bit), and both counters. All other outputs are combinational from state and inputs. Every output defaults to 0.

**S_IDLE_HIT**, active when mem_read or mem_write is asserted:
- Hit read: assert mem_resp and load_lru.
- Hit write: assert load_TD and load_d with d_in=1 on the hit way, plus load_lru and mem_resp. pmem_read=0, so the datapath merges mem_wdata.
- Hit and retry=0: increment hit_count. Clear retry on any hit.
- Miss: victim <= lru_out and miss_count increments.
  - Dirty victim (d_out of the victim way = 1): go to S_WB.
  - Clean victim: go to S_ALLOC.

**S_WB**:
- Drive pmem_write=1 and pmemaddr_sel = victim ? 2 : 1.
- writeback_ctrlsig = ~victim.
- On pmem_resp: load_d on the victim way with d_in=0, then go to S_ALLOC.

**S_ALLOC**:
- Drive pmem_read=1 and pmemaddr_sel=0.
- On pmem_resp, on the victim way: load_TD, load_v with v_in=1, and load_d with d_in=0. Then set retry=1 and return to S_IDLE_HIT, where the request now hits.

**Boundary conditions**:
- Pmem transactions are never aborted. If the CPU drops its request during S_WB or S_ALLOC, the sequence still completes. Back in S_IDLE_HIT with no request, clear retry and issue no mem_resp.
- Counters saturate at 0xFFFF.
- Async reset at any point forces S_IDLE_HIT and clears victim, retry and both counters. An in-flight pmem strobe drops immediately.

## Timing
- Hit: mem_resp is asserted in the same cycle the request is seen (combinational). The array writes on that edge.
- Clean miss: 1 cycle in S_IDLE_HIT, N cycles in S_ALLOC ending with pmem_resp, then the hit cycle. mem_resp arrives N+1 cycles after the request.
- Dirty miss: adds M cycles of S_WB.
- pmem_read/pmem_write stay high until the cycle of pmem_resp inclusive, and drop the following cycle.
- After reset deassertion, every output is 0 until a request arrives.

## Structure
- Add lc3b_cache_state enum {S_IDLE_HIT, S_WB, S_ALLOC} to lc3b_types, for waveform and bench visibility.
- Add constant lc3b_pmemaddr_sel values (PMA_CPU=0, PMA_WAY0=1, PMA_WAY1=2) to lc3b_types.
- One sub-module: sat_counter16, a 16-bit saturating counter with inc and async active-low clear, instantiated twice.

## Test plan
- Read 0x0080 after reset (both ways invalid, lru=0) -> S_ALLOC with pmem_read and pmemaddr_sel=0; on pmem_resp, load_TD0/load_v0 assert; next cycle mem_resp. miss_count=1, hit_count=0.
- Repeat read 0x0082 -> mem_resp in the request cycle, load_lru=1, hit_count=1.
- Write 0x0084, mask 2'b11 -> load_TD0, load_d0 and d_in0=1 with mem_resp in the same cycle.
- Fill way1 with tag 0x002 via read 0x0100, then read 0x0180 with way0 dirty and LRU selecting way0 -> S_WB with pmemaddr_sel=1 and writeback_ctrlsig=1, then S_ALLOC. Data and valid strobes go to way0 only.
- Deassert mem_read mid-S_ALLOC -> pmem_read is held until pmem_resp, the line is installed, and no mem_resp is issued.
- Pulse rst_n low during S_WB -> pmem_write drops asynchronously, state returns to S_IDLE_HIT, and both counters read 0.
